// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I core: fetches over a ready handshake,
// sequences the datapath strobes, counts retired instructions, halts on illegal encodings.
module multicycle_control #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   mem_ready,
    input  logic                   zero,
    input  logic                   lt,
    input  logic                   ltu,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic [2:0]             imm_sel,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   addr_sel,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             alu_op,
    output logic                   pc_we,
    output logic [1:0]             pc_src,
    output logic                   reg_we,
    output logic [1:0]             result_sel,
    output logic                   illegal,
    output logic [DATA_WIDTH-1:0]  instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEMADDR, S_MEMRD,
        S_MEMWR, S_BRANCH, S_JUMP, S_WB, S_HALT
    } state_t;

    state_t     state, next_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       taken;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];

    // State, instruction register, retire counter and sticky halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ir      <= '0;
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && mem_ready)
                ir <= instr;
            if (pc_we)
                instret <= instret + DATA_WIDTH'(1);
            if (next_state == S_HALT)
                illegal <= 1'b1;
        end
    end

    // Branch condition by funct3; 010/011 are not valid branches
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next state and combinational datapath controls
    always_comb begin
        next_state = state;
        imm_sel    = 3'b000;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        reg_we     = 1'b0;
        result_sel = 2'b00;

        case (opcode)
            OP_LUI, OP_AUIPC: imm_sel = 3'b001;
            OP_STORE:         imm_sel = 3'b010;
            OP_LOAD:          imm_sel = 3'b100;
            OP_JAL:           imm_sel = 3'b011;
            OP_BRANCH:        imm_sel = 3'b111;
            default:          imm_sel = 3'b000;
        endcase

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LUI, OP_AUIPC: next_state = S_EXEC;
                    OP_LOAD, OP_STORE:            next_state = S_MEMADDR;
                    OP_BRANCH:                    next_state = S_BRANCH;
                    OP_JAL, OP_JALR:              next_state = S_JUMP;
                    default:                      next_state = S_HALT;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_R:     begin alu_src_a = 1'b1; alu_src_b = 2'b00; alu_op = 2'b10; end
                    OP_I:     begin alu_src_a = 1'b1; alu_src_b = 2'b01; alu_op = 2'b10; end
                    OP_LUI:   begin alu_src_b = 2'b01; alu_op = 2'b11; end
                    default:  begin alu_src_b = 2'b01; alu_op = 2'b00; end
                endcase
                next_state = S_WB;
            end
            S_MEMADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b01;
                next_state = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready)
                    next_state = S_WB;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ready) begin
                    pc_we      = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    next_state = S_HALT;
                end else begin
                    pc_we      = 1'b1;
                    pc_src     = taken ? 2'b01 : 2'b00;
                    next_state = S_FETCH;
                end
            end
            S_JUMP: begin
                reg_we     = 1'b1;
                result_sel = 2'b10;
                pc_we      = 1'b1;
                if (opcode == OP_JALR) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b01;
                    pc_src    = 2'b10;
                end else begin
                    pc_src = 2'b01;
                end
                next_state = S_FETCH;
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                result_sel = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
                next_state = S_FETCH;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase

        // Reset kills any in-flight request or write in the same cycle
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
        end
    end

endmodule
